// File: rtl/cnn_seq_ctrl_pkg.sv
// Shared constants, FSM state encoding and ReLU helpers for the CNN sequencer.
package cnn_pkg;

  localparam int IMG_W  = 28;
  localparam int K      = 5;
  localparam int CONV_W = IMG_W - K + 1;
  localparam int FC_N   = 10;
  localparam int FC_LEN = CONV_W * CONV_W;

  localparam int IMG_AW = 10;
  localparam int CK_AW  = 5;
  localparam int FC_AW  = 14;
  localparam int FM_AW  = 10;
  localparam int FM_DW  = 24;
  localparam int ACC_W  = 32;
  localparam int CLS_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CONV_MAC = 3'd1,
    ST_CONV_WB  = 3'd2,
    ST_FC_MAC   = 3'd3,
    ST_FC_WB    = 3'd4,
    ST_FIN      = 3'd5
  } state_t;

  // Feature-map value: negative clamps to zero, large values saturate at the 24-bit ceiling.
  function automatic logic [FM_DW-1:0] relu_sat(input logic signed [ACC_W-1:0] acc);
    logic [FM_DW-1:0] res;
    if (acc < 32'sd0) begin
      res = 24'd0;
    end else if (acc > 32'sh00FF_FFFF) begin
      res = 24'hFF_FFFF;
    end else begin
      res = acc[FM_DW-1:0];
    end
    return res;
  endfunction

  function automatic logic [ACC_W-1:0] relu32(input logic signed [ACC_W-1:0] acc);
    return acc[ACC_W-1] ? 32'd0 : acc;
  endfunction

endpackage

// File: rtl/cnn_seq_ctrl_argmax.sv
// Running maximum / winning class register; strict-greater compare keeps the lower index on ties.
module cnn_argmax
  import cnn_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             upd,
  input  logic [ACC_W-1:0] val,
  input  logic [CLS_W-1:0] cls,
  output logic [CLS_W-1:0] idx
);

  logic [ACC_W-1:0] max_r;
  logic [CLS_W-1:0] idx_r;

  // Hold the best score seen so far and its class.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      max_r <= 32'd0;
      idx_r <= 4'd0;
    end else if (upd && (val > max_r)) begin
      max_r <= val;
      idx_r <= cls;
    end
  end

  assign idx = idx_r;

endmodule

// File: rtl/cnn_seq_ctrl.sv
// Conv (5x5 on 28x28, ReLU) followed by 10-class FC and argmax, driving an external MAC.
// Optional cycle counter output CYCLE_CNT enabled by macro CNN_SEQ_PERF_CNT_EN.
module cnn_seq_ctrl
  import cnn_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [CLS_W-1:0]        OUT,
  output logic                    MAC_SEL,
  output logic                    MAC_EN,
  output logic                    MAC_CLR,
  input  logic signed [ACC_W-1:0] MAC_ACC,
  output logic [IMG_AW-1:0]       IMG_ADDR,
  output logic [CK_AW-1:0]        CK_ADDR,
  output logic [FC_AW-1:0]        FC_ADDR,
  output logic                    FM_WE,
  output logic [FM_AW-1:0]        FM_WADDR,
  output logic [FM_DW-1:0]        FM_WDATA,
  output logic [FM_AW-1:0]        FM_RADDR
`ifdef CNN_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]             CYCLE_CNT
`endif
);

  state_t state_r, state_s;
  logic [2:0] n_r, m_r;
  logic [4:0] c_r, r_r;
  logic [9:0] j_r;
  logic [3:0] i_r;
  logic [CLS_W-1:0] idx_s;
  logic am_upd_s;

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:     state_s = START ? ST_CONV_MAC : ST_IDLE;
      ST_CONV_MAC: state_s = (n_r == 3'(K-1) && m_r == 3'(K-1)) ? ST_CONV_WB : ST_CONV_MAC;
      ST_CONV_WB:  state_s = (r_r == 5'(CONV_W-1) && c_r == 5'(CONV_W-1)) ? ST_FC_MAC : ST_CONV_MAC;
      ST_FC_MAC:   state_s = (j_r == 10'(FC_LEN-1)) ? ST_FC_WB : ST_FC_MAC;
      ST_FC_WB:    state_s = (i_r == 4'(FC_N-1)) ? ST_FIN : ST_FC_MAC;
      ST_FIN:      state_s = ST_IDLE;
      default:     state_s = ST_IDLE;
    endcase
  end

  // State, loop counters and the registered result outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      n_r <= 3'd0; m_r <= 3'd0; c_r <= 5'd0; r_r <= 5'd0;
      j_r <= 10'd0; i_r <= 4'd0;
      DONE <= 1'b0;
      OUT <= 4'd0;
    end else begin
      state_r <= state_s;
      DONE <= (state_r == ST_FIN);
      if (state_r == ST_FIN) OUT <= idx_s;
      case (state_r)
        ST_IDLE: begin
          n_r <= 3'd0; m_r <= 3'd0; c_r <= 5'd0; r_r <= 5'd0;
          j_r <= 10'd0; i_r <= 4'd0;
        end
        ST_CONV_MAC: begin
          if (n_r == 3'(K-1)) begin
            n_r <= 3'd0;
            m_r <= (m_r == 3'(K-1)) ? 3'd0 : m_r + 3'd1;
          end else begin
            n_r <= n_r + 3'd1;
          end
        end
        ST_CONV_WB: begin
          if (c_r == 5'(CONV_W-1)) begin
            c_r <= 5'd0;
            r_r <= (r_r == 5'(CONV_W-1)) ? 5'd0 : r_r + 5'd1;
          end else begin
            c_r <= c_r + 5'd1;
          end
        end
        ST_FC_MAC: j_r <= (j_r == 10'(FC_LEN-1)) ? 10'd0 : j_r + 10'd1;
        ST_FC_WB:  i_r <= (i_r == 4'(FC_N-1)) ? 4'd0 : i_r + 4'd1;
        default: ;
      endcase
    end
  end

  // MAC, memory address and feature-map write decode; everything idles at zero.
  always_comb begin
    MAC_SEL  = 1'b0;
    MAC_EN   = 1'b0;
    MAC_CLR  = 1'b0;
    IMG_ADDR = 10'd0;
    CK_ADDR  = 5'd0;
    FC_ADDR  = 14'd0;
    FM_WE    = 1'b0;
    FM_WADDR = 10'd0;
    FM_WDATA = 24'd0;
    FM_RADDR = 10'd0;
    am_upd_s = 1'b0;
    case (state_r)
      ST_IDLE: MAC_CLR = 1'b1;
      ST_CONV_MAC: begin
        MAC_EN   = 1'b1;
        IMG_ADDR = (IMG_AW'(r_r) + IMG_AW'(m_r)) * IMG_AW'(IMG_W) + IMG_AW'(c_r) + IMG_AW'(n_r);
        CK_ADDR  = CK_AW'(m_r) * CK_AW'(K) + CK_AW'(n_r);
      end
      ST_CONV_WB: begin
        FM_WE    = 1'b1;
        FM_WADDR = FM_AW'(r_r) * FM_AW'(CONV_W) + FM_AW'(c_r);
        FM_WDATA = relu_sat(MAC_ACC);
        MAC_CLR  = 1'b1;
      end
      ST_FC_MAC: begin
        MAC_SEL  = 1'b1;
        MAC_EN   = 1'b1;
        FM_RADDR = j_r;
        FC_ADDR  = FC_AW'(i_r) * FC_AW'(FC_LEN) + FC_AW'(j_r);
      end
      ST_FC_WB: begin
        MAC_CLR  = 1'b1;
        am_upd_s = 1'b1;
      end
      default: ;
    endcase
  end

  assign BUSY = (state_r != ST_IDLE);

  cnn_argmax u_argmax (
    .CLK (CLK),
    .RST (RST),
    .clr (state_r == ST_IDLE),
    .upd (am_upd_s),
    .val (relu32(MAC_ACC)),
    .cls (i_r),
    .idx (idx_s)
  );

`ifdef CNN_SEQ_PERF_CNT_EN
  // Busy-cycle counter, restarted on each accepted START and saturating at full scale.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CYCLE_CNT <= 16'd0;
    end else if (state_r == ST_IDLE && START) begin
      CYCLE_CNT <= 16'd0;
    end else if (BUSY && CYCLE_CNT != 16'hFFFF) begin
      CYCLE_CNT <= CYCLE_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: doc/cnn_seq_ctrl.md
CNN_SEQ_CTRL -- requirements
Module: cnn_seq_ctrl

Interface
REQ-001 Parameters: IMG_W 28 input width/height; K 5 kernel size; CONV_W 24 conv output width (IMG_W-K+1); FC_N 10 classes.
REQ-002 CLK  in  1  single clock; all logic on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 START  in  1  begin inference; sampled only in IDLE.
REQ-005 BUSY  out  1  high in every state except IDLE.
REQ-006 DONE  out  1  one-cycle pulse when OUT is valid.
REQ-007 OUT  out  4  winning class index, held until next DONE.
REQ-008 MAC_SEL  out  1  0 = conv operands, 1 = FC operands.
REQ-009 MAC_EN  out  1  accumulate the addressed operand pair this cycle.
REQ-010 MAC_CLR  out  1  clear the external accumulator at this edge.
REQ-011 MAC_ACC  in  32  signed accumulator; includes every MAC_EN issued before the current cycle.
REQ-012 IMG_ADDR  out  10  image pixel address.
REQ-013 CK_ADDR  out  5  conv kernel tap address.
REQ-014 FC_ADDR  out  14  FC weight address.
REQ-015 FM_WE, FM_WADDR[9:0], FM_WDATA[23:0]  out  feature-map write port.
REQ-016 FM_RADDR  out  10  feature-map read address for the FC phase.

Function
REQ-017 States: IDLE, CONV_MAC, CONV_WB, FC_MAC, FC_WB, FIN; FIN lasts one cycle and returns to IDLE.
REQ-018 IDLE->CONV_MAC on START; START outside IDLE is ignored, with no queuing.
REQ-019 CONV_MAC: 25 cycles per output (r,c) with MAC_SEL=0, MAC_EN=1, IMG_ADDR=(r+m)*IMG_W+(c+n), CK_ADDR=m*K+n; n fastest, then m.
REQ-020 CONV_WB: 1 cycle; FM_WE=1, FM_WADDR=r*CONV_W+c, FM_WDATA = 0 if MAC_ACC<0, else MAC_ACC saturated to 24'hFFFFFF (ReLU); MAC_CLR=1.
REQ-021 After CONV_WB, c advances, then r. After (23,23) go to FC_MAC; otherwise go back to CONV_MAC.
REQ-022 FC_MAC: 576 cycles per class i with MAC_SEL=1, MAC_EN=1, FM_RADDR=j, FC_ADDR=i*576+j; j runs 0..575.
REQ-023 FC_WB: 1 cycle; relu(MAC_ACC) is compared with the running max; strictly greater updates max and index, so ties keep the lower index; MAC_CLR=1.
REQ-024 After FC_WB of i=9 go to FIN; otherwise go back to FC_MAC with i+1.
REQ-025 FIN: OUT<=index, DONE=1. If all classes give 0, OUT=0.
REQ-026 Latency: DONE is high in the cycle following the 20747th edge after the edge that samples START (14976 conv + 5770 FC + 1 FIN).
REQ-027 MAC_CLR=1 throughout IDLE. MAC_EN=0 and FM_WE=0 in every state not named above.
REQ-028 Every address output is 0 when its phase is inactive.

Reset
REQ-029 RST=1 at an edge forces IDLE from any state, including mid-inference; the partial result is discarded and no DONE is produced.
REQ-030 Reset values: BUSY=0, DONE=0, OUT=0, MAC_EN=0, MAC_CLR=1, FM_WE=0, all addresses 0, all counters and running max/index 0.
REQ-031 RST has priority over START in the same cycle.

Configuration
REQ-032 Macro CNN_SEQ_PERF_CNT_EN defined: adds output CYCLE_CNT[15:0], cleared on the START-accept edge, +1 per BUSY cycle, saturating at 16'hFFFF, held after FIN, reset to 0.
REQ-033 Macro undefined: the CYCLE_CNT port and its logic are absent; all other behaviour is identical.

Structure
REQ-034 Shared package cnn_pkg holds IMG_W, K, CONV_W, FC_N, FC_LEN=576, the state enum, and the address widths.
REQ-035 One sub-module, cnn_argmax: running max/index register with clear, update strobe, and strict-greater compare.

Verification
REQ-036 Kernel all 1, image all 1, FC row 3 all 1, other rows 0 -> every FM_WDATA=25; DONE at cycle 20747; OUT=3.
REQ-037 FC rows 2 and 7 give equal maximum -> OUT=2. All FC weights negative -> OUT=0.
REQ-038 RST pulsed at cycle 5000 -> IDLE next cycle, BUSY=0, no DONE; a new START then completes normally at 20747.
REQ-039 START re-asserted while BUSY -> ignored; exactly one DONE pulse, one cycle wide.
REQ-040 Conv address trace: first 25 IMG_ADDR = 0..4, 28..32, 56..60, 84..88, 112..116; first FM_WADDR=0, last=575.
REQ-041 CNN_SEQ_PERF_CNT_EN build -> CYCLE_CNT=20747 after DONE, unchanged in IDLE.
